// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_e;

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/adder_32_bit.sv
// 32-bit ripple adder with carry in and carry out.
module adder_32_bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);

    logic [32:0] full_sum;

    always_comb begin
        full_sum = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
        o_sum    = full_sum[31:0];
        o_cout   = full_sum[32];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm, one quotient bit
// per cycle through a single shared adder used in subtract mode.
module div_sequencer
    import div_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_funct,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            is_rem_q, is_rem_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] add_sub;
    logic            cout;
    logic            signed_op;
    logic            start_rem;
    logic            ok;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    assign shifted = {r_q[XLEN-2:0], q_q[XLEN-1]};

    // S - D computed as S + ~D + 1; cout=1 means no borrow.
    adder_32_bit u_adder (
        .i_a    (shifted),
        .i_b    (~d_q),
        .i_cin  (1'b1),
        .o_sum  (add_sub),
        .o_cout (cout)
    );

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        r_d       = r_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;
        signed_op = (i_funct == F_DIV) || (i_funct == F_REM);
        start_rem = (i_funct == F_REM) || (i_funct == F_REMU);
        // 33-bit compare: a set R[31] means the shifted value already exceeds D.
        ok        = r_q[XLEN-1] | cout;
        quot      = (sign_a_q ^ sign_b_q) ? (~q_q + 32'd1) : q_q;
        rem       = sign_a_q ? (~r_q + 32'd1) : r_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sign_a_d = signed_op & i_dividend[XLEN-1];
                    sign_b_d = signed_op & i_divisor[XLEN-1];
                    is_rem_d = start_rem;
                    q_d      = i_dividend;
                    d_d      = i_divisor;
                    r_d      = '0;
                    cnt_d    = '0;
                    if (i_divisor == '0) begin
                        result_d = start_rem ? i_dividend : DIV0_QUOT;
                        state_d  = DONE;
                    end else if (signed_op && i_dividend == INT_MIN && i_divisor == '1) begin
                        result_d = start_rem ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else if (FAST_ZERO && i_dividend == '0) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = PREP;
                    end
                end
            end
            PREP: begin
                q_d     = sign_a_q ? (~q_q + 32'd1) : q_q;
                d_d     = sign_b_q ? (~d_q + 32'd1) : d_q;
                r_d     = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                r_d   = ok ? add_sub : shifted;
                q_d   = {q_q[XLEN-2:0], ok};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = is_rem_q ? rem : quot;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == PREP) || (state_d == ITER) || (state_d == FIX);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            q_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_rem_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            r_q      <= r_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_rem_q <= is_rem_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-table and randomized checks of div_sequencer against an arithmetic reference.
module tb_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks;
    int failures;

    div_sequencer dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_funct    (funct),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
        int          inj;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference from RISC-V M rules using native arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic is_signed;
        logic is_rem;
        is_signed = ~f[0];
        is_rem    = f[1];
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0 || a == 32'd0) return 1;
        if (~f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 35;
    endfunction

    // Start at edge 0; inj>0 raises a competing start during that cycle.
    task automatic run_op(input vec_t v);
        int          cyc;
        int          lat;
        logic        busy_ok;
        logic [31:0] got;
        @(negedge clk);
        funct    = v.f;
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct    = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        cyc      = 1;
        lat      = -1;
        busy_ok  = 1'b1;
        got      = 32'd0;
        while (cyc <= 60) begin
            if (valid) begin
                lat = cyc;
                got = result;
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else if (busy !== 1'b1 && v.exp_lat > 1) begin
                busy_ok = 1'b0;
            end else if (busy !== 1'b0 && v.exp_lat == 1) begin
                busy_ok = 1'b0;
            end
            if (cyc == v.inj) begin
                start    = 1'b1;
                funct    = 2'b01;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (lat >= 0) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, " result"}, got, v.exp_res);
        chk({v.name, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({v.name, " after pulse"}, {30'd0, busy, valid}, 32'd0);
        chk({v.name, " result hold"}, result, v.exp_res);
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        funct    = 2'b00;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset state", {busy, valid, result[29:0]}, 32'd0);
        chk("reset result", result, 32'd0);

        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 35, 0, "divu 100/7"});
        vecs.push_back('{2'b11, 32'd100, 32'd7, 32'd2, 35, 0, "remu 100/7"});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 0, "div -7/2"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 0, "rem -7/2"});
        vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 35, 0, "rem 7/-2"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, 0, "divu max/1"});
        vecs.push_back('{2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "div 5/0"});
        vecs.push_back('{2'b10, 32'd5, 32'd0, 32'd5, 1, 0, "rem 5/0"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div ovf"});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem ovf"});
        vecs.push_back('{2'b00, 32'd0, 32'd5, 32'd0, 1, 0, "div 0/5"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'd1, 32'h8000_0000, 35, 0, "div min/1"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFE, 35, 0, "rem -8/3"});
        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 35, 10, "start busy"});
        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 35, 35, "start done"});
        vecs.push_back('{2'b10, 32'd5, 32'd0, 32'd5, 1, 1, "start done sp"});

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset during an operation aborts it without a valid pulse.
        begin
            int saw_valid;
            @(negedge clk);
            funct    = 2'b01;
            dividend = 32'd100;
            divisor  = 32'd7;
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (19) begin
                @(posedge clk);
                #1;
            end
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            chk("reset abort", {busy, valid, 30'd0}, 32'd0);
            chk("reset abort result", result, 32'd0);
            saw_valid = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (valid) saw_valid++;
            end
            chk("no valid after abort", 32'(saw_valid), 32'd0);
            rv = '{2'b01, 32'd9, 32'd3, 32'd3, 35, 0, "divu 9/3 post reset"};
            run_op(rv);
        end

        for (int n = 0; n < 40; n++) begin
            rv.f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: rv.b = 32'd0;
                1: begin rv.a = 32'd0; end
                2: begin rv.a = 32'h8000_0000; rv.b = 32'hFFFF_FFFF; end
                3: begin rv.a = $urandom; rv.b = $urandom_range(1, 15); end
                default: begin rv.a = $urandom; rv.b = $urandom >> $urandom_range(0, 31); end
            endcase
            if (n % 8 == 1) rv.a = 32'd0;
            else if (rv.a == 32'd0 && n % 8 != 1) rv.a = $urandom | 32'd1;
            rv.exp_res = ref_result(rv.f, rv.a, rv.b);
            rv.exp_lat = ref_latency(rv.f, rv.a, rv.b);
            rv.inj     = (n % 5 == 0) ? 7 : 0;
            rv.name    = $sformatf("rand%0d f=%0d %h/%h", n, rv.f, rv.a, rv.b);
            run_op(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
